// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: writer side of the RegFile write port.
// Collects writeback (MEM/WB) and JAL link writes, queues them in program order and
// drives the RegFile write port at one write per cycle.
// Optional feature: define WB_BYPASS_EN to enable pending-write forwarding to ID-stage
// readers (lookupHit/lookupData). Without it the lookup outputs are tied to 0.

module regfile_write_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     wbValid,
    input  logic [AW-1:0]            wbAddress,
    input  logic [DW-1:0]            wbData,
    output logic                     wbReady,
    input  logic                     jalValid,
    input  logic [DW-1:0]            jalData,
    output logic                     jalReady,
    output logic                     regShouldWrite,
    output logic [AW-1:0]            regWriteAddress,
    output logic [DW-1:0]            writeData,
    output logic                     isJal,
    output logic [DW-1:0]            regWriteData_jal,
    input  logic [AW-1:0]            lookupAddress1,
    input  logic [AW-1:0]            lookupAddress2,
    output logic                     lookupHit1,
    output logic                     lookupHit2,
    output logic [DW-1:0]            lookupData1,
    output logic [DW-1:0]            lookupData2,
    output logic [$clog2(DEPTH):0]   pendingCount
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [AW-1:0] LinkReg = AW'(31);

    logic [AW-1:0] addrMem [DEPTH];
    logic [DW-1:0] dataMem [DEPTH];

    logic [PW-1:0] headQ, headD;
    logic [PW-1:0] tailQ, tailD;
    logic [CW-1:0] countQ, countD;
    logic [CW-1:0] free;
    logic [PW-1:0] jalSlot;
    logic          wbPush;
    logic          jalPush;
    logic          pop;

    // Readiness depends only on the registered count; a same-cycle pop does not free a slot.
    always_comb begin
        free     = CW'(DEPTH) - countQ;
        wbReady  = (free >= CW'(1));
        jalReady = (free >= (wbValid ? CW'(2) : CW'(1)));
        // Address-0 requests handshake but never occupy a slot.
        wbPush   = wbValid && wbReady && (wbAddress != '0);
        jalPush  = jalValid && jalReady;
        pop      = (countQ != '0);
        // WB belongs to the older instruction, so it takes the first free slot.
        jalSlot  = wbPush ? tailQ + PW'(1) : tailQ;
        tailD    = tailQ + PW'(wbPush) + PW'(jalPush);
        headD    = pop ? headQ + PW'(1) : headQ;
        countD   = countQ - CW'(pop) + CW'(wbPush) + CW'(jalPush);
    end

    // Queue storage; contents need no reset since occupancy is tracked by the count.
    always_ff @(posedge CLK) begin
        if (wbPush) begin
            addrMem[tailQ] <= wbAddress;
            dataMem[tailQ] <= wbData;
        end
        if (jalPush) begin
            addrMem[jalSlot] <= LinkReg;
            dataMem[jalSlot] <= jalData;
        end
    end

    // Pointers, count and the registered write port; the head is popped every non-empty cycle.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            headQ           <= '0;
            tailQ           <= '0;
            countQ          <= '0;
            regShouldWrite  <= 1'b0;
            regWriteAddress <= '0;
            writeData       <= '0;
        end else begin
            headQ  <= headD;
            tailQ  <= tailD;
            countQ <= countD;
            if (pop) begin
                regShouldWrite  <= 1'b1;
                regWriteAddress <= addrMem[headQ];
                writeData       <= dataMem[headQ];
            end else begin
                regShouldWrite  <= 1'b0;
            end
        end
    end

    assign pendingCount     = countQ;
    assign isJal            = 1'b0;
    assign regWriteData_jal = '0;

`ifdef WB_BYPASS_EN
    // Newest pending value for addr: output register first, then queue entries oldest to
    // newest so later matches override earlier ones.
    function automatic logic [DW:0] lookupPending(input logic [AW-1:0] addr);
        logic          hit;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        if (regShouldWrite && (regWriteAddress == addr)) begin
            hit  = 1'b1;
            data = writeData;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = headQ + PW'(i);
            if ((CW'(i) < countQ) && (addrMem[idx] == addr)) begin
                hit  = 1'b1;
                data = dataMem[idx];
            end
        end
        if (addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
        return {hit, data};
    endfunction

    // Forwarding lookups for the two ID-stage read ports.
    always_comb begin
        {lookupHit1, lookupData1} = lookupPending(lookupAddress1);
        {lookupHit2, lookupData2} = lookupPending(lookupAddress2);
    end
`else
    logic unusedLookup;
    assign unusedLookup = ^{lookupAddress1, lookupAddress2};
    assign lookupHit1   = 1'b0;
    assign lookupHit2   = 1'b0;
    assign lookupData1  = '0;
    assign lookupData2  = '0;
`endif

endmodule
